// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle between the instruction datapath (master) and the
// nibble sequencer (slave); operand and result width is 4*NIBBLES bits.
interface alu_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_result;
    logic         resp_carry;
    logic         resp_zero;
    logic         resp_lt;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_carry, resp_zero, resp_lt
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, resp_ready,
        output req_ready, resp_valid, resp_result, resp_carry, resp_zero, resp_lt
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs a wide operation through a 4-bit ALU one nibble per cycle, LSB first,
// chaining carry/borrow and assembling the result and flags.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_nibble_sequencer_if.slave bus,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_mode,
    output logic                 alu_carry_f,
    output logic                 alu_borrow_f,
    input  logic [3:0]           alu_c,
    input  logic [3:0]           alu_flags
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBB = 4'h3,
        OP_SHL = 4'h4, OP_SHR = 4'h5
    } op_t;

    state_t       state, state_next;
    logic [KW-1:0] k;
    logic [3:0]   op_reg;
    logic [W-1:0] a_reg, b_reg, acc;
    logic         cin_reg, carry_reg, borrow_reg, lt_reg;

    logic [W-1:0] result_r;
    logic         carry_r, zero_r, lt_r;

    logic         is_add, is_sub;
    logic [W-1:0] a_sh, b_sh, shl_sh, acc_next;
    logic [3:0]   res_nib;
    logic         lt_next, final_carry;

    // The zero flag is recomputed from the assembled word, so the ALU's own is unused.
    logic unused_zero_flag;
    assign unused_zero_flag = alu_flags[2];

    function automatic logic [3:0] mode_of(input logic [3:0] op);
        if (op == OP_ADD || op == OP_ADC)      return 4'b0001;
        else if (op == OP_SUB || op == OP_SBB) return 4'b0011;
        else if (op >= 4'h4 && op <= 4'hB)     return op;
        else                                   return 4'b1111;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_next   = state;
        alu_a        = 4'h0;
        alu_b        = 4'h0;
        alu_mode     = 4'b1111;
        alu_carry_f  = 1'b0;
        alu_borrow_f = 1'b0;

        is_add = (op_reg == OP_ADD) || (op_reg == OP_ADC);
        is_sub = (op_reg == OP_SUB) || (op_reg == OP_SBB);

        // Shifting by 4k brings nibble k to the bottom without a variable part-select.
        a_sh   = a_reg >> {k, 2'b00};
        b_sh   = b_reg >> {k, 2'b00};
        shl_sh = (a_reg << 1) >> {k, 2'b00};

        if (state == S_RUN) begin
            alu_a        = a_sh[3:0];
            alu_b        = b_sh[3:0];
            alu_mode     = mode_of(op_reg);
            alu_carry_f  = is_add && ((k == '0) ? (op_reg == OP_ADC && cin_reg) : carry_reg);
            alu_borrow_f = is_sub && ((k == '0) ? (op_reg == OP_SBB && cin_reg) : borrow_reg);
        end

        // Shifts need the bit that crosses in from the neighbouring nibble.
        res_nib = alu_c;
        if (op_reg == OP_SHL)      res_nib = alu_c | {3'b000, shl_sh[0]};
        else if (op_reg == OP_SHR) res_nib = alu_c | {a_sh[4], 3'b000};

        acc_next = acc | (W'(res_nib) << {k, 2'b00});
        lt_next  = (a_sh[3:0] != b_sh[3:0]) ? alu_flags[3] : lt_reg;

        if (is_add)                final_carry = alu_flags[0];
        else if (is_sub)           final_carry = alu_flags[1];
        else if (op_reg == OP_SHL) final_carry = a_reg[W-1];
        else if (op_reg == OP_SHR) final_carry = a_reg[0];
        else                       final_carry = 1'b0;

        case (state)
            S_IDLE:  if (bus.req_valid) state_next = S_RUN;
            S_RUN:   if (k == K_LAST) state_next = S_DONE;
            S_DONE:  if (bus.resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            k          <= '0;
            op_reg     <= 4'h0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc        <= '0;
            cin_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
            lt_reg     <= 1'b0;
            result_r   <= '0;
            carry_r    <= 1'b0;
            zero_r     <= 1'b0;
            lt_r       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_reg     <= bus.req_op;
                        a_reg      <= bus.req_a;
                        b_reg      <= bus.req_b;
                        cin_reg    <= bus.req_cin;
                        k          <= '0;
                        acc        <= '0;
                        carry_reg  <= 1'b0;
                        borrow_reg <= 1'b0;
                        lt_reg     <= 1'b0;
                    end
                end
                S_RUN: begin
                    k      <= k + 1'b1;
                    acc    <= acc_next;
                    lt_reg <= lt_next;
                    if (is_add) carry_reg  <= alu_flags[0];
                    if (is_sub) borrow_reg <= alu_flags[1];
                    // Response registers move only here, so they hold steady through DONE.
                    if (k == K_LAST) begin
                        result_r <= acc_next;
                        zero_r   <= (acc_next == '0);
                        carry_r  <= final_carry;
                        lt_r     <= lt_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = (state == S_IDLE);
    assign bus.resp_valid  = (state == S_DONE);
    assign bus.resp_result = result_r;
    assign bus.resp_carry  = carry_r;
    assign bus.resp_zero   = zero_r;
    assign bus.resp_lt     = lt_r;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench: behavioural 4-bit ALU plus a word-level reference model
// of each operation; directed cases followed by randomized requests.
module tb_alu_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_nibble_sequencer_if #(.NIBBLES(N)) bus ();

    logic [3:0] alu_a, alu_b, alu_mode, alu_c, alu_flags;
    logic       alu_carry_f, alu_borrow_f;
    logic [4:0] alu_sum, alu_diff;

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_mode     (alu_mode),
        .alu_carry_f  (alu_carry_f),
        .alu_borrow_f (alu_borrow_f),
        .alu_c        (alu_c),
        .alu_flags    (alu_flags)
    );

    // 4-bit ALU model
    assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_carry_f};
    assign alu_diff = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_borrow_f};
    always_comb begin
        case (alu_mode)
            4'b0001: alu_c = alu_sum[3:0];
            4'b0011: alu_c = alu_diff[3:0];
            4'h4:    alu_c = alu_a << 1;
            4'h5:    alu_c = alu_a >> 1;
            4'h6:    alu_c = alu_a & alu_b;
            4'h7:    alu_c = alu_a | alu_b;
            4'h8:    alu_c = ~alu_a;
            4'h9:    alu_c = alu_a ^ alu_b;
            4'hA:    alu_c = ~(alu_a & alu_b);
            4'hB:    alu_c = ~(alu_a | alu_b);
            default: alu_c = 4'h0;
        endcase
        alu_flags = {alu_a < alu_b, alu_c == 4'h0, alu_diff[4], alu_sum[4]};
    end

    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_mode(input logic [3:0] op);
        if (op <= 4'h1)      return 4'b0001;
        else if (op <= 4'h3) return 4'b0011;
        else if (op <= 4'hB) return op;
        else                 return 4'b1111;
    endfunction

    // Word-level reference model
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, b, input logic cin,
                         output logic [W-1:0] r, output logic c, output logic lt);
        logic [W:0] wide;
        c = 1'b0;
        case (op)
            4'h0: begin wide = {1'b0, a} + {1'b0, b};                r = wide[W-1:0]; c = wide[W]; end
            4'h1: begin wide = {1'b0, a} + {1'b0, b} + (W+1)'(cin);  r = wide[W-1:0]; c = wide[W]; end
            4'h2: begin r = a - b; c = (a < b); end
            4'h3: begin r = a - b - W'(cin); c = ({1'b0, a} < ({1'b0, b} + (W+1)'(cin))); end
            4'h4: begin r = a << 1; c = a[W-1]; end
            4'h5: begin r = a >> 1; c = a[0]; end
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = ~a;
            4'h9: r = a ^ b;
            4'hA: r = ~(a & b);
            4'hB: r = ~(a | b);
            default: r = '0;
        endcase
        lt = (a < b);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, b, input logic cin,
                          input int hold);
        logic [W-1:0] er;
        logic ec, elt;
        int lat;
        model(op, a, b, cin, er, ec, elt);
        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_cin    = cin;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            check("alu_mode_run", alu_mode, exp_mode(op));
            @(negedge clk);
            lat++;
        end
        check("latency", lat, N);
        check("resp_result", bus.resp_result, er);
        check("resp_carry", bus.resp_carry, ec);
        check("resp_zero", bus.resp_zero, er == '0);
        check("resp_lt", bus.resp_lt, elt);
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 4'h0;
            bus.req_a     = W'($urandom);
            @(negedge clk);
            check("hold_valid", bus.resp_valid, 1'b1);
            check("hold_ready", bus.req_ready, 1'b0);
            check("hold_result", bus.resp_result, er);
            check("hold_carry", bus.resp_carry, ec);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("post_valid", bus.resp_valid, 1'b0);
        check("post_ready", bus.req_ready, 1'b1);
        check("idle_mode", alu_mode, 4'b1111);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 4'h0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_cin    = 1'b0;
        bus.resp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_result", bus.resp_result, 16'h0);
        check("rst_flags", {bus.resp_carry, bus.resp_zero, bus.resp_lt}, 3'b000);
        check("rst_alu_mode", alu_mode, 4'b1111);
        check("rst_alu_ops", {alu_a, alu_b, alu_carry_f, alu_borrow_f}, 10'h0);
        rst_n = 1'b1;

        run_op(4'h0, 16'h0FFF, 16'h0001, 1'b0, 0);
        run_op(4'h0, 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(4'h1, 16'h00FF, 16'h0000, 1'b1, 0);
        run_op(4'h2, 16'h0000, 16'h0001, 1'b0, 0);
        run_op(4'h2, 16'h1000, 16'h0001, 1'b0, 0);
        run_op(4'h3, 16'h1000, 16'h0FFF, 1'b1, 0);
        run_op(4'h4, 16'h8421, 16'h0000, 1'b0, 0);
        run_op(4'h5, 16'h8421, 16'h0000, 1'b0, 0);
        run_op(4'h9, 16'h5A5A, 16'h5A5A, 1'b0, 0);
        run_op(4'h0, 16'h1234, 16'h4321, 1'b0, 10);

        // Reset during nibble 2 abandons the request
        @(negedge clk);
        bus.req_op    = 4'h0;
        bus.req_a     = 16'h1111;
        bus.req_b     = 16'h2222;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.resp_valid, 1'b0);
        check("midrst_ready", bus.req_ready, 1'b1);
        check("midrst_result", bus.resp_result, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 1) @(negedge clk);
        check("midrst_no_resp", bus.resp_valid, 1'b0);
        run_op(4'h2, 16'hABCD, 16'h1234, 1'b0, 0);
        run_op(4'hE, 16'h1234, 16'h5678, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                   1'($urandom), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle controller that executes NIBBLES×4-bit operations on the 4-bit ALU by driving its operand, mode and carry/borrow inputs one nibble per cycle and assembling the wide result and flags. Sits between the instruction datapath (valid/ready request and response) and the ALU, and is the only driver of the ALU's inputs.

## Interface
- NIBBLES, 4, operand width in nibbles (W = 4×NIBBLES); legal range 2–8.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  operation code (encoding below).
- req_a, req_b  in  W  operands.
- req_cin  in  1  initial carry (ADC) or borrow (SBB).
- resp_valid  out  1  result available; held until resp_ready.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  W  assembled result.
- resp_carry  out  1  carry-out / borrow-out / shifted-out bit.
- resp_zero  out  1  resp_result == 0.
- resp_lt  out  1  unsigned req_a < req_b.
- alu_a, alu_b  out  4  ALU operand nibbles.
- alu_mode  out  4  ALU mode.
- alu_carry_f, alu_borrow_f  out  1  ALU carry/borrow inputs.
- alu_c  in  4  ALU result nibble.
- alu_flags  in  4  ALU flags: [0] carry-out, [1] borrow-out, [2] zero, [3] a<b.

## Operation
- req_op: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 SHL, 5 SHR, 6 AND, 7 OR, 8 NOT, 9 XOR, A NAND, B NOR, C–F invalid.
- alu_mode issued: ADD/ADC → 0001; SUB/SBB → 0011; 4–B → same code; invalid → 1111 (ALU returns 0).
- States: IDLE → RUN on req_valid & req_ready (latch op, a, b, cin; k=0). RUN: nibble k = 0..NIBBLES-1, LSB first; after nibble NIBBLES-1 → DONE. DONE → IDLE on resp_ready.
- RUN drives alu_a = a[4k+3:4k], alu_b = b[4k+3:4k] combinationally from registered operands and k.
- Carry chain: alu_carry_f = (k==0 ? (ADC ? cin : 0) : carry_reg); carry_reg ← alu_flags[0] each ADD/ADC nibble. Borrow analogous via alu_borrow_f, alu_flags[1] for SUB/SBB.
- SHL: result nibble k = alu_c | {3'b0, a[4k-1]} for k>0; resp_carry = a[W-1].
- SHR: result nibble k = alu_c | {a[4k+4], 3'b0} for k<NIBBLES-1; resp_carry = a[0].
- Logic ops and invalid: resp_carry = 0.
- resp_carry for ADD/ADC/SUB/SBB = carry/borrow captured at the last nibble.
- resp_lt: starts 0; at each nibble where the a and b nibbles differ, lt ← alu_flags[3]; equal nibbles leave it unchanged. Computed for every op.
- resp_zero computed from the final assembled resp_result, never from per-nibble alu_flags[2].
- Sequencer samples only the flag bit relevant to the issued mode; other alu_flags bits ignored.
- Outside RUN: alu_a = alu_b = 0, alu_mode = 1111, alu_carry_f = alu_borrow_f = 0.

## Timing
- Reset: state IDLE, req_ready 1, resp_valid 0, resp_result 0, resp_carry/zero/lt 0, k 0, carry/borrow regs 0.
- Accept at edge T; nibbles captured at edges T+1..T+NIBBLES; resp_valid high from edge T+NIBBLES.
- Latency NIBBLES cycles accept-to-resp_valid; min issue interval NIBBLES+2 cycles (DONE, IDLE).
- resp_* stable while resp_valid; update only at the final RUN capture.
- resp_ready low in DONE: hold indefinitely; req_ready stays 0.
- req_valid outside IDLE ignored; no overlap of requests.
- rst_n low mid-RUN or DONE: immediate abandonment, all outputs to reset values; no response for the abandoned request.

## Test plan
- NIBBLES=4, ADD 0x0FFF + 0x0001 → resp_result 0x1000, carry 0, zero 0, lt 0; resp_valid exactly 4 cycles after accept; alu_mode 0001 in each RUN cycle.
- ADD 0xFFFF + 0x0001 → 0x0000, carry 1, zero 1; ADC 0x00FF + 0x0000, cin 1 → 0x0100, carry 0.
- SUB 0x0000 − 0x0001 → 0xFFFF, carry (borrow) 1, lt 1; SUB 0x1000 − 0x0001 → 0x0FFF, borrow 0, lt 0.
- SHL 0x8421 → 0x0842, carry 1; SHR 0x8421 → 0x4210, carry 1; XOR 0x5A5A ^ 0x5A5A → 0x0000, zero 1, lt 0.
- Backpressure: resp_ready low 10 cycles after resp_valid → outputs stable, req_ready 0, a new req_valid ignored; resp_ready high → IDLE next cycle, then accept.
- rst_n pulsed low during nibble 2 → resp_valid 0, req_ready 1, resp_result 0 immediately; next request completes correctly; invalid op 0xE → 0x0000, zero 1, carry 0.
